cart_banked_sram_ctrl: RTL and testbench

// - Next-generation SRAM controller for the Atari XL/XE SD cartridge CPLD. It owns the single

---
 rtl/cart_pkg.sv | 20 ++
 rtl/cart_banked_sram_ctrl_if.sv | 18 +
 rtl/fi2_edge_sync.sv | 31 +++
 rtl/cart_banked_sram_ctrl.sv | 179 +++++++++++++++++
 tb/tb_cart_banked_sram_ctrl.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cart_pkg.sv
// Shared constants for the banked cartridge SRAM controller: FSM state
// encodings, CCTL register offsets and the default register window base.
package cart_pkg;

  localparam logic [2:0] ST_IDLE         = 3'd0;
  localparam logic [2:0] ST_CART_RD      = 3'd1;
  localparam logic [2:0] ST_CART_WR_WAIT = 3'd2;
  localparam logic [2:0] ST_CART_WR      = 3'd3;
  localparam logic [2:0] ST_UC_RD        = 3'd4;
  localparam logic [2:0] ST_UC_WR        = 3'd5;
  localparam logic [2:0] ST_UC_DONE      = 3'd6;

  localparam logic [2:0] REG_BANK4 = 3'd0;
  localparam logic [2:0] REG_BANK5 = 3'd1;
  localparam logic [2:0] REG_RDCTL = 3'd7;

  // cart_addr[7:3] of the $D5E8-$D5EF CCTL window
  localparam logic [4:0] REG_BASE_DEF = 5'b11101;

endpackage

// File: rtl/cart_banked_sram_ctrl_if.sv
// Microcontroller side of the SRAM controller: level request with a
// 4-phase acknowledge, explicit address and data ports.
interface cart_banked_sram_ctrl_if #(
  parameter int AW = 17
);
  logic          uc_req;
  logic          uc_we;
  logic [AW-1:0] uc_addr;
  logic [7:0]    uc_wdata;
  logic [7:0]    uc_rdata;
  logic          uc_ack;

  modport master (output uc_req, uc_we, uc_addr, uc_wdata,
                  input  uc_rdata, uc_ack);

  modport slave  (input  uc_req, uc_we, uc_addr, uc_wdata,
                  output uc_rdata, uc_ack);
endinterface

// File: rtl/fi2_edge_sync.sv
// Brings an asynchronous strobe (Atari Phi2) into the clk domain and
// derives single-cycle rise/fall pulses aligned with the synced level.
module fi2_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);
  logic r_meta;
  logic r_sync;
  logic r_prev;

  // two-flop synchroniser followed by the edge-detect history register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;
endmodule

// File: rtl/cart_banked_sram_ctrl.sv
// SRAM arbiter for the XL/XE SD cartridge: Atari bus (priority) and uC
// share one SRAM; S4/S5 windows each have their own bank register.
//
// state        | meaning
// IDLE         | no access; waits for a cart request or a uC request on Fi2 fall
// CART_RD      | Atari read of the SRAM, RAM_CYCLES clk
// CART_WR_WAIT | Atari write selected, waiting for late write data (Fi2 fall)
// CART_WR      | Atari write into the SRAM, RAM_CYCLES clk
// UC_RD        | uC read of the SRAM, RAM_CYCLES clk
// UC_WR        | uC write into the SRAM, RAM_CYCLES clk
// UC_DONE      | uc_ack high until uc_req drops; cart requests still served
module cart_banked_sram_ctrl
  import cart_pkg::*;
#(
  parameter int         BANK_BITS  = 4,
  parameter int         RAM_CYCLES = 4,
  parameter logic [4:0] REG_BASE   = REG_BASE_DEF,
  parameter logic [1:0] RD_RESET   = 2'b11
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_cart_fi2,
  input  logic                   i_cart_s4,
  input  logic                   i_cart_s5,
  input  logic                   i_cart_cctl,
  input  logic                   i_cart_rw,
  input  logic [12:0]            i_cart_addr,
  input  logic [7:0]             i_cart_din,
  output logic [7:0]             o_cart_dout,
  output logic                   o_cart_doe,
  output logic                   o_cart_rd4,
  output logic                   o_cart_rd5,
  input  logic                   i_cart_write_enable,
  output logic [12+BANK_BITS:0]  o_ram_addr,
  input  logic [7:0]             i_ram_din,
  output logic [7:0]             o_ram_dout,
  output logic                   o_ram_doe,
  output logic                   o_ram_oe_n,
  output logic                   o_ram_we_n,
  cart_banked_sram_ctrl_if.slave uc_bus
);
  localparam int             PW      = $clog2(RAM_CYCLES);
  localparam logic [PW-1:0]  PH_DATA = PW'(RAM_CYCLES - 2);
  localparam logic [PW-1:0]  PH_LAST = PW'(RAM_CYCLES - 1);

  logic w_fi2_sync, w_rise, w_fall;
  logic r_s4, r_s5, r_cctl, r_rw, r_cyc, r_rise_d, r_fall_d, r_cpend;
  logic [12:0] r_addr;
  logic [7:0]  r_din, r_cart_dout, r_uc_rdata, w_rb;
  logic [BANK_BITS-1:0] r_bank4, r_bank5;
  logic r_rd4, r_rd5, r_uc_ack;
  logic [2:0]    r_state;
  logic [PW-1:0] r_phase;
  logic w_win4, w_win5, w_win, w_reg, w_rd_st, w_wr_st, w_uc_st, w_acc, w_take;

  fi2_edge_sync u_fi2 (
    .clk     (clk),
    .rst     (rst),
    .i_async (i_cart_fi2),
    .o_sync  (w_fi2_sync),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  assign w_win4  = ~r_s4;
  assign w_win5  = r_s4 & ~r_s5;
  assign w_win   = w_win4 | w_win5;
  assign w_reg   = ~r_cctl & (r_addr[7:3] == REG_BASE);
  assign w_rd_st = (r_state == ST_CART_RD) | (r_state == ST_UC_RD);
  assign w_wr_st = (r_state == ST_CART_WR) | (r_state == ST_UC_WR);
  assign w_uc_st = (r_state == ST_UC_RD) | (r_state == ST_UC_WR);
  assign w_acc   = w_rd_st | w_wr_st;
  assign w_take  = r_cpend & ((r_state == ST_IDLE) | (r_state == ST_UC_DONE));

  // register read-back value for the offset in the snapshot
  always_comb begin
    w_rb = 8'hFF;
    case (r_addr[2:0])
      REG_BANK4: w_rb = 8'(r_bank4);
      REG_BANK5: w_rb = 8'(r_bank5);
      REG_RDCTL: w_rb = 8'({r_rd5, r_rd4});
      default:   w_rb = 8'hFF;
    endcase
  end

  // Atari cycle snapshot; din is re-captured on fall since write data is late
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s4 <= 1'b1; r_s5 <= 1'b1; r_cctl <= 1'b1; r_rw <= 1'b1;
      r_addr <= '0; r_din <= '0; r_cyc <= 1'b0;
      r_rise_d <= 1'b0; r_fall_d <= 1'b0;
    end else begin
      if (w_rise) begin
        r_s4 <= i_cart_s4; r_s5 <= i_cart_s5; r_cctl <= i_cart_cctl;
        r_rw <= i_cart_rw; r_addr <= i_cart_addr;
      end
      if (w_rise | w_fall) r_din <= i_cart_din;
      if (w_rise)      r_cyc <= 1'b1;
      else if (w_fall) r_cyc <= 1'b0;
      r_rise_d <= w_rise;
      r_fall_d <= w_fall;
    end
  end

  // CCTL register writes and RD4/RD5 update on unselected cycles only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bank4 <= '0; r_bank5 <= '0;
      {r_rd5, r_rd4} <= RD_RESET;
      {o_cart_rd5, o_cart_rd4} <= RD_RESET;
    end else begin
      if (r_fall_d & w_reg & ~r_rw) begin
        case (r_addr[2:0])
          REG_BANK4: r_bank4 <= r_din[BANK_BITS-1:0];
          REG_BANK5: r_bank5 <= r_din[BANK_BITS-1:0];
          REG_RDCTL: {r_rd5, r_rd4} <= r_din[7:6];
          default: ;
        endcase
      end
      if (r_rise_d & ~w_win & ~w_reg) {o_cart_rd5, o_cart_rd4} <= {r_rd5, r_rd4};
    end
  end

  // cart request latch, so a request arriving during a uC access is not lost
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                  r_cpend <= 1'b0;
    else if (r_rise_d & w_win & (r_rw | i_cart_write_enable)) r_cpend <= 1'b1;
    else if (w_take)                                          r_cpend <= 1'b0;
  end

  // arbitration FSM, access phase counter and read data capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE; r_phase <= '0; r_uc_ack <= 1'b0;
      r_uc_rdata <= '0; r_cart_dout <= '0;
    end else begin
      r_phase <= w_acc ? r_phase + PW'(1) : '0;
      if (r_rise_d & w_reg & r_rw) r_cart_dout <= w_rb;
      case (r_state)
        ST_IDLE, ST_UC_DONE: begin
          if (r_cpend) begin
            r_state <= r_rw ? ST_CART_RD : ST_CART_WR_WAIT;
          end else if (r_state == ST_UC_DONE) begin
            if (!uc_bus.uc_req) begin
              r_uc_ack <= 1'b0;
              r_state  <= ST_IDLE;
            end
          end else if (w_fall & uc_bus.uc_req & ~r_uc_ack) begin
            r_state <= uc_bus.uc_we ? ST_UC_WR : ST_UC_RD;
          end
        end
        ST_CART_WR_WAIT: if (!r_cyc) r_state <= ST_CART_WR;
        ST_CART_RD, ST_CART_WR: begin
          if (r_state == ST_CART_RD && r_phase == PH_DATA) r_cart_dout <= i_ram_din;
          if (r_phase == PH_LAST) r_state <= r_uc_ack ? ST_UC_DONE : ST_IDLE;
        end
        ST_UC_RD, ST_UC_WR: begin
          if (r_state == ST_UC_RD && r_phase == PH_DATA) r_uc_rdata <= i_ram_din;
          if (r_phase == PH_LAST) begin
            r_uc_ack <= 1'b1;
            r_state  <= ST_UC_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_ram_oe_n = ~w_rd_st;
  assign o_ram_doe  = w_wr_st;
  assign o_ram_we_n = ~(w_wr_st & (r_phase != '0) & (r_phase != PH_LAST));
  assign o_ram_addr = w_uc_st ? uc_bus.uc_addr
                    : (w_win4 ? {r_bank4, r_addr} : {r_bank5, r_addr});
  assign o_ram_dout = (r_state == ST_UC_WR) ? uc_bus.uc_wdata : r_din;
  assign o_cart_doe  = w_fi2_sync & r_cyc & r_rw & (w_win | w_reg);
  assign o_cart_dout = r_cart_dout;
  assign uc_bus.uc_rdata = r_uc_rdata;
  assign uc_bus.uc_ack   = r_uc_ack;
endmodule

// File: tb/tb_cart_banked_sram_ctrl.sv
// Bench for cart_banked_sram_ctrl: behavioural SRAM plus a bank/RD model,
// fixed scenarios followed by randomized Atari traffic.
module tb_cart_banked_sram_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic cart_fi2 = 0, cart_s4 = 1, cart_s5 = 1, cart_cctl = 1, cart_rw = 1;
  logic [12:0] cart_addr = '0;
  logic [7:0]  cart_din = '0, cart_dout, ram_din, ram_dout;
  logic cart_doe, cart_rd4, cart_rd5, cart_we_en = 0;
  logic [16:0] ram_addr;
  logic ram_doe, ram_oe_n, ram_we_n;

  cart_banked_sram_ctrl_if #(.AW(17)) ifc ();

  cart_banked_sram_ctrl dut (
    .clk(clk), .rst(rst), .i_cart_fi2(cart_fi2), .i_cart_s4(cart_s4),
    .i_cart_s5(cart_s5), .i_cart_cctl(cart_cctl), .i_cart_rw(cart_rw),
    .i_cart_addr(cart_addr), .i_cart_din(cart_din), .o_cart_dout(cart_dout),
    .o_cart_doe(cart_doe), .o_cart_rd4(cart_rd4), .o_cart_rd5(cart_rd5),
    .i_cart_write_enable(cart_we_en), .o_ram_addr(ram_addr), .i_ram_din(ram_din),
    .o_ram_dout(ram_dout), .o_ram_doe(ram_doe), .o_ram_oe_n(ram_oe_n),
    .o_ram_we_n(ram_we_n), .uc_bus(ifc)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:131071];
  assign ram_din = mem[ram_addr];

  int n_checks = 0, n_errors = 0;
  int oe_cnt = 0, oe_fi2hi = 0, we_cnt = 0, we_pulses = 0;
  logic we_prev = 1'b1;
  logic [16:0] oe_addr;
  logic [7:0]  we_data;
  logic [3:0]  m_bank4 = 0, m_bank5 = 0;

  // SRAM behaviour and strobe bookkeeping, sampled on the falling clk edge
  always @(negedge clk) begin
    if (!ram_oe_n) begin
      oe_cnt++;
      oe_addr = ram_addr;
      if (cart_fi2) oe_fi2hi++;
    end
    if (!ram_we_n) begin
      we_cnt++;
      we_data = ram_dout;
      mem[ram_addr] = ram_dout;
      if (we_prev) we_pulses++;
    end
    we_prev = ram_we_n;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one full Fi2 cycle: 12 clk high, 12 clk low; write data appears late
  task automatic atari_cycle(input logic s4, s5, cctl, rw, input logic [12:0] a,
                             input logic [7:0] d, output logic [7:0] dout,
                             output logic doe, output int oe_hi);
    int oe0;
    @(negedge clk);
    cart_s4 = s4; cart_s5 = s5; cart_cctl = cctl; cart_rw = rw; cart_addr = a;
    cart_din = rw ? 8'h00 : ~d;
    cart_fi2 = 1'b1;
    oe0 = oe_cnt;
    repeat (6) @(negedge clk);
    cart_din = d;
    repeat (6) @(negedge clk);
    dout = cart_dout; doe = cart_doe; oe_hi = oe_cnt - oe0;
    cart_fi2 = 1'b0;
    repeat (11) @(negedge clk);
    cart_s4 = 1; cart_s5 = 1; cart_cctl = 1; cart_rw = 1;
  endtask

  function automatic logic [12:0] reg_addr(input logic [2:0] off);
    return {5'b10101, 5'b11101, off};
  endfunction

  task automatic uc_access(input logic we, input logic [16:0] a, input logic [7:0] wd,
                           output logic [7:0] rd, output bit ok, output int drop);
    @(negedge clk);
    ifc.uc_we = we; ifc.uc_addr = a; ifc.uc_wdata = wd; ifc.uc_req = 1'b1;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (ifc.uc_ack) begin ok = 1; break; end
    end
    rd = ifc.uc_rdata;
    ifc.uc_req = 1'b0;
    drop = -1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (!ifc.uc_ack) begin drop = i; break; end
    end
  endtask

  logic [7:0] dv, rdv, wd, expd;
  logic de;
  int oh, oe0, we0, wp0, fh0, drop;
  bit ok;
  logic [12:0] a;
  logic [16:0] ua;
  logic s4, s5;
  int op, w;

  initial begin
    for (int i = 0; i < 131072; i++) mem[i] = 8'($urandom);
    ifc.uc_req = 0; ifc.uc_we = 0; ifc.uc_addr = '0; ifc.uc_wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_oe_n", ram_oe_n, 1);
    chk("rst_we_n", ram_we_n, 1);
    chk("rst_ram_doe", ram_doe, 0);
    chk("rst_cart_doe", cart_doe, 0);
    chk("rst_uc_ack", ifc.uc_ack, 0);
    chk("rst_uc_rdata", ifc.uc_rdata, 0);
    chk("rst_cart_dout", cart_dout, 0);
    chk("rst_rd", {cart_rd5, cart_rd4}, 2'b11);

    // bank4 = 7, then read $8123
    atari_cycle(1, 1, 0, 0, reg_addr(3'd0), 8'h07, dv, de, oh); m_bank4 = 4'h7;
    oe0 = oe_cnt;
    atari_cycle(0, 1, 1, 1, 13'h0123, 8'h00, dv, de, oh);
    chk("s4_rd_addr", oe_addr, 17'h0E123);
    chk("s4_rd_oe_len", oe_cnt - oe0, 4);
    chk("s4_rd_data", dv, mem[17'h0E123]);
    chk("s4_rd_doe", de, 1);

    // register read-back
    atari_cycle(1, 1, 0, 0, reg_addr(3'd1), 8'hA5, dv, de, oh); m_bank5 = 4'h5;
    oe0 = oe_cnt;
    atari_cycle(1, 1, 0, 1, reg_addr(3'd1), 8'h00, dv, de, oh);
    chk("rb_bank5", dv, 8'h05);
    chk("rb_doe", de, 1);
    atari_cycle(1, 1, 0, 1, reg_addr(3'd2), 8'h00, dv, de, oh);
    chk("rb_d5ea", dv, 8'hFF);
    chk("rb_no_oe", oe_cnt - oe0, 0);

    // RD4/RD5 update deferred to an unselected cycle
    atari_cycle(1, 1, 0, 0, reg_addr(3'd7), 8'h40, dv, de, oh);
    chk("rd_after_wr", {cart_rd5, cart_rd4}, 2'b11);
    atari_cycle(0, 1, 1, 1, 13'h0456, 8'h00, dv, de, oh);
    chk("rd_after_sel", {cart_rd5, cart_rd4}, 2'b11);
    atari_cycle(1, 1, 1, 1, 13'h0000, 8'h00, dv, de, oh);
    chk("rd_after_unsel", {cart_rd5, cart_rd4}, 2'b01);
    chk("unsel_doe", de, 0);

    // S5 writes gated by cart_write_enable
    expd = mem[{4'h5, 13'h0777}];
    wp0 = we_pulses;
    atari_cycle(1, 0, 1, 0, 13'h0777, 8'h3C, dv, de, oh);
    chk("wr_dis_pulses", we_pulses - wp0, 0);
    chk("wr_dis_mem", mem[{4'h5, 13'h0777}], expd);
    cart_we_en = 1'b1;
    wp0 = we_pulses; we0 = we_cnt;
    atari_cycle(1, 0, 1, 0, 13'h0777, 8'h3C, dv, de, oh);
    chk("wr_en_pulses", we_pulses - wp0, 1);
    chk("wr_en_len", we_cnt - we0, 2);
    chk("wr_en_dout", we_data, 8'h3C);
    chk("wr_en_mem", mem[{4'h5, 13'h0777}], 8'h3C);

    // uC read of the top address while the Atari idles
    oe0 = oe_cnt; fh0 = oe_fi2hi;
    fork
      begin repeat (4) atari_cycle(1, 1, 1, 1, 13'h0, 8'h0, dv, de, oh); end
      uc_access(1'b0, 17'h1FFFF, 8'h00, rdv, ok, drop);
    join
    chk("uc_rd_ack", ok, 1);
    chk("uc_rd_data", rdv, mem[17'h1FFFF]);
    chk("uc_rd_drop", drop, 1);
    chk("uc_rd_oe_len", oe_cnt - oe0, 4);
    chk("uc_rd_in_low", oe_fi2hi - fh0, 0);

    // uC write, then the Atari reads it back through bank4
    wd = 8'($urandom);
    fork
      begin repeat (4) atari_cycle(1, 1, 1, 1, 13'h0, 8'h0, dv, de, oh); end
      uc_access(1'b1, {m_bank4, 13'h0456}, wd, rdv, ok, drop);
    join
    chk("uc_wr_ack", ok, 1);
    chk("uc_wr_mem", mem[{m_bank4, 13'h0456}], wd);
    atari_cycle(0, 1, 1, 1, 13'h0456, 8'h00, dv, de, oh);
    chk("uc_wr_cart_rd", dv, wd);

    // uC request mid-Fi2-high with back-to-back Atari reads
    ua = 17'($urandom);
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          a = 13'($urandom);
          atari_cycle(0, 1, 1, 1, a, 8'h00, dv, de, oh);
          chk("b2b_data", dv, mem[{m_bank4, a}]);
          chk("b2b_oe_hi", oh, 4);
        end
      end
      begin
        repeat (6) @(negedge clk);
        uc_access(1'b0, ua, 8'h00, rdv, ok, drop);
        chk("b2b_uc_ack", ok, 1);
        chk("b2b_uc_data", rdv, mem[ua]);
      end
    join

    // randomized traffic against the bank/SRAM model
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 3);
      w  = $urandom_range(0, 2);
      s4 = (w == 1); s5 = (w != 1);
      a  = 13'($urandom);
      wd = 8'($urandom);
      case (op)
        0: begin
          if (w == 1) begin
            atari_cycle(1, 1, 0, 0, reg_addr(3'd1), wd, dv, de, oh); m_bank5 = wd[3:0];
          end else begin
            atari_cycle(1, 1, 0, 0, reg_addr(3'd0), wd, dv, de, oh); m_bank4 = wd[3:0];
          end
        end
        1: begin
          atari_cycle(s4, s5, 1, 1, a, 8'h00, dv, de, oh);
          chk("rnd_rd_data", dv, mem[{(s4 ? m_bank5 : m_bank4), a}]);
          chk("rnd_rd_oe", oh, 4);
        end
        2: begin
          atari_cycle(s4, s5, 1, 0, a, wd, dv, de, oh);
          chk("rnd_wr_mem", mem[{(s4 ? m_bank5 : m_bank4), a}], wd);
        end
        default: begin
          op = $urandom_range(0, 6);
          atari_cycle(1, 1, 0, 1, reg_addr(3'(op)), 8'h00, dv, de, oh);
          expd = (op == 0) ? {4'h0, m_bank4} : (op == 1) ? {4'h0, m_bank5} : 8'hFF;
          chk("rnd_rb", dv, expd);
          chk("rnd_rb_oe", oh, 0);
        end
      endcase
    end

    // reset in the middle of a uC write
    fork
      begin repeat (4) atari_cycle(1, 1, 1, 1, 13'h0, 8'h0, dv, de, oh); end
      begin
        @(negedge clk);
        ifc.uc_we = 1; ifc.uc_addr = 17'h00100; ifc.uc_wdata = 8'h99; ifc.uc_req = 1;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
          @(negedge clk);
          if (!ram_we_n) begin ok = 1; break; end
        end
        chk("mid_wr_seen", ok, 1);
        rst = 1'b1; ifc.uc_req = 1'b0;
        #1;
        chk("mid_rst_we_n", ram_we_n, 1);
        chk("mid_rst_doe", ram_doe, 0);
        chk("mid_rst_ack", ifc.uc_ack, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("post_rst_ack", ifc.uc_ack, 0);
      end
    join
    m_bank4 = 0; m_bank5 = 0;
    chk("post_rst_rd", {cart_rd5, cart_rd4}, 2'b11);
    atari_cycle(1, 1, 0, 1, reg_addr(3'd0), 8'h00, dv, de, oh);
    chk("post_rst_bank4", dv, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
